// File: rtl/arith_pkg.sv
// Shared arithmetic-unit constants: FSM state encoding
// and the default operand width for the serial datapath.
package arith_pkg;

  localparam int ARITH_W = 4;

  typedef logic [1:0] st_t;

  localparam st_t ST_IDLE = 2'd0;
  localparam st_t ST_RUN  = 2'd1;
  localparam st_t ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow.
// Two half-subtractor stages joined by an OR on the borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // stage 1: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // stage 2: (a - b) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, start/busy/done.
// Ports: clk, rst_n, start, a, b -> busy, done, diff, borrow_out.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int W = ARITH_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = $clog2(W);

  st_t          state_q;
  st_t          state_d;
  logic [W-1:0] a_sr;
  logic [W-1:0] b_sr;
  logic [W-2:0] res_sr;
  logic [W-1:0] res_nxt;
  logic         borrow_q;
  logic [CW-1:0] cnt_q;
  logic         last;
  logic         accept;
  logic         run;
  logic         fs_d;
  logic         fs_bout;
  logic         busy_d;
  logic         done_d;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] diff_q;
  logic         bo_q;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last   = (cnt_q == CW'(W - 1));
  assign accept = (state_q == ST_IDLE) && start;
  assign run    = (state_q == ST_RUN);

  // new bit enters at the top; full word on last step
  assign res_nxt = {fs_d, res_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs are flops fed from the next state
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (run) begin
      a_sr     <= {1'b0, a_sr[W-1:1]};
      b_sr     <= {1'b0, b_sr[W-1:1]};
      res_sr   <= res_nxt[W-1:1];
      borrow_q <= fs_bout;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        diff_q <= res_nxt;
        bo_q   <= fs_bout;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule
